// File: rtl/core_irq_pkg.sv
// Shared constants for the platform interrupt controller: register map,
// default sizing and the reserved "no interrupt" ID.
package core_irq_pkg;

    localparam int unsigned DEF_NUM_SRC = 8;
    localparam int unsigned DEF_PRIO_W  = 3;

    localparam int unsigned CFG_ADDR_W = 6;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CID_W      = 8;

    localparam logic [CFG_ADDR_W-1:0] ADDR_PRIO_BASE = 6'h00;
    localparam logic [CFG_ADDR_W-1:0] ADDR_ENABLE    = 6'h20;
    localparam logic [CFG_ADDR_W-1:0] ADDR_THRESH    = 6'h21;
    localparam logic [CFG_ADDR_W-1:0] ADDR_CLAIM     = 6'h22;
    localparam logic [CFG_ADDR_W-1:0] ADDR_PENDING   = 6'h23;

    localparam int unsigned ID_NONE = 0;

endpackage

// File: rtl/core_irq_ctrl_if.sv
// Single-cycle register access port of the interrupt controller.
interface core_irq_ctrl_if;
    import core_irq_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_we;
    logic [CFG_ADDR_W-1:0] cfg_addr;
    logic [CFG_DATA_W-1:0] cfg_wdata;
    logic [CFG_DATA_W-1:0] cfg_rdata;
    logic                  cfg_rvalid;

    modport master (
        output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, cfg_rvalid
    );

endinterface

// File: rtl/core_irq_arbiter.sv
// Combinational pick of the highest-priority eligible source; equal
// priorities resolve to the lowest ID.
module core_irq_arbiter
    import core_irq_pkg::*;
#(
    parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter  int unsigned PRIO_W  = DEF_PRIO_W,
    localparam int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0]             pending,
    input  logic [NUM_SRC-1:0]             enable,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]              thresh,
    output logic [ID_W-1:0]                best_id_c,
    output logic [PRIO_W-1:0]              best_prio_c
);

    // Scan from the top ID down so a later (lower) ID wins on equal priority.
    always_comb begin
        best_id_c   = ID_W'(ID_NONE);
        best_prio_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i] && enable[i] && (prio[i] > thresh) && (prio[i] >= best_prio_c)) begin
                best_id_c   = ID_W'(i + 1);
                best_prio_c = prio[i];
            end
        end
    end

endmodule

// File: rtl/core_irq_ctrl.sv
// Platform interrupt controller: level gateways, pending/in-service tracking,
// claim/complete register port, registered interrupt and wake outputs.
module core_irq_ctrl
    import core_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned PRIO_W  = DEF_PRIO_W
) (
    input  logic               clk,
    input  logic               rst,
    core_irq_ctrl_if.slave     cfg,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               irq_out,
    output logic               wake_out
);

    localparam int unsigned ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]             enable_q, enable_d;
    logic [NUM_SRC-1:0]             pending_q, pending_d;
    logic [NUM_SRC-1:0]             in_service_q, in_service_d;
    logic [NUM_SRC-1:0]             armed_q, armed_d;
    logic [PRIO_W-1:0]              thresh_q, thresh_d;
    logic [CFG_DATA_W-1:0]          rdata_q, rdata_d;
    logic                           rvalid_q, rvalid_d;
    logic                           irq_d, wake_d;

    logic [ID_W-1:0]    best_id_c;
    logic [PRIO_W-1:0]  best_prio_c;
    logic               rd_c, wr_c, claim_c, complete_c;
    logic [NUM_SRC-1:0] gw_fire_c, claim_mask_c, complete_mask_c, prio_nz_c;
    logic               unused_wdata;

    core_irq_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arbiter (
        .pending     (pending_q),
        .enable      (enable_q),
        .prio        (prio_q),
        .thresh      (thresh_q),
        .best_id_c   (best_id_c),
        .best_prio_c (best_prio_c)
    );

    assign rd_c       = cfg.cfg_valid & ~cfg.cfg_we;
    assign wr_c       = cfg.cfg_valid & cfg.cfg_we;
    assign claim_c    = rd_c && (cfg.cfg_addr == ADDR_CLAIM);
    assign complete_c = wr_c && (cfg.cfg_addr == ADDR_CLAIM);

    // An armed gateway latches a high level once and then ignores the source.
    assign gw_fire_c = src_irq & armed_q & ~pending_q;

    assign unused_wdata = ^cfg.cfg_wdata[CFG_DATA_W-1:CID_W];

    assign cfg.cfg_rdata  = rdata_q;
    assign cfg.cfg_rvalid = rvalid_q;

    // Per-source claim/complete decode and non-zero priority flags.
    always_comb begin
        claim_mask_c    = '0;
        complete_mask_c = '0;
        prio_nz_c       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_nz_c[i] = (prio_q[i] != '0);
            if (claim_c && (best_id_c == ID_W'(i + 1))) begin
                claim_mask_c[i] = 1'b1;
            end
            if (complete_c && (cfg.cfg_wdata[CID_W-1:0] == CID_W'(i + 1)) && in_service_q[i]) begin
                complete_mask_c[i] = 1'b1;
            end
        end
    end

    // Next-state for configuration, tracking bits, read path and outputs.
    always_comb begin
        prio_d       = prio_q;
        enable_d     = enable_q;
        thresh_d     = thresh_q;
        pending_d    = (pending_q | gw_fire_c) & ~claim_mask_c;
        armed_d      = (armed_q & ~gw_fire_c) | complete_mask_c;
        in_service_d = (in_service_q | claim_mask_c) & ~complete_mask_c;
        rvalid_d     = rd_c;
        rdata_d      = rdata_q;
        irq_d        = (best_prio_c != '0);
        wake_d       = |(pending_q & enable_q & prio_nz_c);

        if (wr_c) begin
            if (cfg.cfg_addr == ADDR_ENABLE) begin
                enable_d = cfg.cfg_wdata[NUM_SRC-1:0];
            end
            if (cfg.cfg_addr == ADDR_THRESH) begin
                thresh_d = cfg.cfg_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg.cfg_addr == ADDR_PRIO_BASE + CFG_ADDR_W'(i)) begin
                    prio_d[i] = cfg.cfg_wdata[PRIO_W-1:0];
                end
            end
        end

        if (rd_c) begin
            rdata_d = '0;
            case (cfg.cfg_addr)
                ADDR_ENABLE:  rdata_d[NUM_SRC-1:0] = enable_q;
                ADDR_THRESH:  rdata_d[PRIO_W-1:0]  = thresh_q;
                ADDR_CLAIM:   rdata_d[ID_W-1:0]    = best_id_c;
                ADDR_PENDING: rdata_d[NUM_SRC-1:0] = pending_q;
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (cfg.cfg_addr == ADDR_PRIO_BASE + CFG_ADDR_W'(i)) begin
                            rdata_d[PRIO_W-1:0] = prio_q[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= '0;
            enable_q     <= '0;
            thresh_q     <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            armed_q      <= '1;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            irq_out      <= 1'b0;
            wake_out     <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            enable_q     <= enable_d;
            thresh_q     <= thresh_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            armed_q      <= armed_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            irq_out      <= irq_d;
            wake_out     <= wake_d;
        end
    end

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Bench for core_irq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_core_irq_ctrl;
    import core_irq_pkg::*;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int PMASK = (1 << PW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_irq;
    logic         irq_out;
    logic         wake_out;

    core_irq_ctrl_if cfg_if ();

    core_irq_ctrl #(
        .NUM_SRC (N),
        .PRIO_W  (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg_if),
        .src_irq  (src_irq),
        .irq_out  (irq_out),
        .wake_out (wake_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state, indexed by source ID where natural.
    int           m_prio [1:N];
    int           m_thr;
    bit [N-1:0]   m_en, m_pend, m_armed, m_insvc;
    bit           m_irq, m_wake, m_rvalid;
    logic [31:0]  m_rdata;
    bit           chk_on = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_best();
        int b  = 0;
        int bp = 0;
        for (int id = 1; id <= N; id++) begin
            if (m_pend[id-1] && m_en[id-1] && m_prio[id] > m_thr && m_prio[id] > bp) begin
                b  = id;
                bp = m_prio[id];
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] model_read(int a, int bid);
        if (a < N)                     return 32'(m_prio[a+1]);
        if (a == int'(ADDR_ENABLE))    return 32'(m_en);
        if (a == int'(ADDR_THRESH))    return 32'(m_thr);
        if (a == int'(ADDR_CLAIM))     return 32'(bid);
        if (a == int'(ADDR_PENDING))   return 32'(m_pend);
        return 32'h0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_update();
        int         bid, a, cid;
        bit [N-1:0] p0 = m_pend;
        bit [N-1:0] a0 = m_armed;
        bit [N-1:0] s0 = m_insvc;
        logic [31:0] wd = cfg_if.cfg_wdata;
        if (rst) begin
            for (int id = 1; id <= N; id++) m_prio[id] = 0;
            m_thr = 0; m_en = '0; m_pend = '0; m_insvc = '0; m_armed = '1;
            m_irq = 0; m_wake = 0; m_rvalid = 0; m_rdata = '0;
            return;
        end
        bid    = model_best();
        m_irq  = (bid != 0);
        m_wake = 0;
        for (int id = 1; id <= N; id++)
            if (p0[id-1] && m_en[id-1] && m_prio[id] != 0) m_wake = 1;
        a        = int'(cfg_if.cfg_addr);
        m_rvalid = cfg_if.cfg_valid && !cfg_if.cfg_we;
        if (m_rvalid) m_rdata = model_read(a, bid);
        for (int i = 0; i < N; i++) begin
            if (src_irq[i] && a0[i] && !p0[i]) begin
                m_pend[i]  = 1;
                m_armed[i] = 0;
            end
        end
        if (m_rvalid && a == int'(ADDR_CLAIM) && bid != 0) begin
            m_pend[bid-1]  = 0;
            m_insvc[bid-1] = 1;
        end
        if (cfg_if.cfg_valid && cfg_if.cfg_we) begin
            if (a == int'(ADDR_CLAIM)) begin
                cid = int'(wd[7:0]);
                if (cid >= 1 && cid <= N && s0[cid-1]) begin
                    m_insvc[cid-1] = 0;
                    m_armed[cid-1] = 1;
                end
            end else if (a < N) begin
                m_prio[a+1] = int'(wd) & PMASK;
            end else if (a == int'(ADDR_ENABLE)) begin
                m_en = wd[N-1:0];
            end else if (a == int'(ADDR_THRESH)) begin
                m_thr = int'(wd) & PMASK;
            end
        end
    endfunction

    // Single compare process: outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("irq_out", 32'(irq_out), 32'(m_irq));
            check("wake_out", 32'(wake_out), 32'(m_wake));
            check("cfg_rvalid", 32'(cfg_if.cfg_rvalid), 32'(m_rvalid));
            if (m_rvalid) check("cfg_rdata", cfg_if.cfg_rdata, m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic cfg_wr(int addr, logic [31:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = 6'(addr);
        cfg_if.cfg_wdata = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic cfg_rd(int addr, logic [31:0] exp, string name);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_addr  = 6'(addr);
        step();
        cfg_if.cfg_valid = 1'b0;
        check(name, cfg_if.cfg_rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_irq = '0;
        cfg_if.cfg_valid = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        src_irq = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_wdata = '0;
        do_reset();
        chk_on = 1'b1;

        // Reset state
        check("rst_irq", 32'(irq_out), 0);
        check("rst_wake", 32'(wake_out), 0);
        check("rst_rvalid", 32'(cfg_if.cfg_rvalid), 0);
        check("rst_rdata", cfg_if.cfg_rdata, 0);
        cfg_rd(32'h23, 0, "rst_pending");
        cfg_rd(32'h20, 0, "rst_enable");

        // Single source: latency, claim, complete with level still high
        cfg_wr(2, 5);
        cfg_wr(32'h20, 32'h04);
        cfg_wr(32'h21, 0);
        src_irq[2] = 1'b1;
        step();
        check("s1_irq_edge1", 32'(irq_out), 0);
        cfg_rd(32'h23, 32'h04, "s1_pending");
        check("s1_irq_edge2", 32'(irq_out), 1);
        cfg_rd(32'h22, 3, "s1_claim");
        step();
        check("s1_irq_drop", 32'(irq_out), 0);
        cfg_wr(32'h22, 3);
        step();
        cfg_rd(32'h23, 32'h04, "s1_repend");

        // Priority order and lowest-ID tie-break
        do_reset();
        cfg_wr(1, 4);
        cfg_wr(4, 6);
        cfg_wr(6, 6);
        cfg_wr(32'h20, 32'h52);
        src_irq = 8'h52;
        idle(2);
        cfg_rd(32'h22, 5, "s2_claim_a");
        cfg_rd(32'h22, 7, "s2_claim_b");
        cfg_rd(32'h22, 2, "s2_claim_c");
        cfg_rd(32'h22, 0, "s2_claim_none");

        // Threshold masks irq but not wake
        do_reset();
        cfg_wr(0, 2);
        cfg_wr(32'h21, 2);
        cfg_wr(32'h20, 32'h01);
        src_irq = 8'h01;
        idle(3);
        check("s3_irq_masked", 32'(irq_out), 0);
        check("s3_wake", 32'(wake_out), 1);
        cfg_wr(32'h21, 1);
        check("s3_irq_write_edge", 32'(irq_out), 0);
        step();
        check("s3_irq_unmasked", 32'(irq_out), 1);

        // Gateway hold-off and ignored completes
        do_reset();
        cfg_wr(3, 3);
        cfg_wr(32'h20, 32'h08);
        src_irq = 8'h08;
        idle(2);
        cfg_rd(32'h22, 4, "s4_claim");
        repeat (2) begin
            src_irq = 8'h00; step();
            src_irq = 8'h08; step();
        end
        cfg_rd(32'h23, 0, "s4_holdoff");
        src_irq = 8'h00;
        step();
        cfg_wr(32'h22, 4);
        idle(2);
        cfg_rd(32'h23, 0, "s4_low_complete");
        src_irq = 8'h08;
        idle(2);
        cfg_rd(32'h22, 4, "s4_claim2");
        src_irq = 8'h00;
        cfg_wr(32'h22, 9);
        cfg_wr(32'h22, 0);
        cfg_wr(32'h22, 32'hFFFF_FF00);
        src_irq = 8'h08;
        idle(2);
        cfg_rd(32'h23, 0, "s4_still_insvc");
        cfg_wr(32'h22, 4);
        step();
        cfg_rd(32'h23, 32'h08, "s4_rearm");

        // Reset during a claim read with ID6 in service
        do_reset();
        cfg_wr(5, 1);
        cfg_wr(32'h20, 32'h20);
        src_irq = 8'h20;
        idle(2);
        cfg_rd(32'h22, 6, "s5_claim");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_addr  = 6'h22;
        rst = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        check("s5_no_rvalid", 32'(cfg_if.cfg_rvalid), 0);
        check("s5_rdata", cfg_if.cfg_rdata, 0);
        check("s5_irq", 32'(irq_out), 0);
        check("s5_wake", 32'(wake_out), 0);
        cfg_rd(32'h23, 0, "s5_pend_cleared");
        cfg_rd(32'h23, 32'h20, "s5_gateway_rearmed");
        cfg_rd(5, 0, "s5_prio_cleared");
        cfg_rd(32'h20, 0, "s5_enable_cleared");
        cfg_rd(32'h21, 0, "s5_thresh_cleared");

        // Disabled source keeps its pending bit
        do_reset();
        cfg_wr(7, 7);
        cfg_wr(32'h20, 32'h80);
        src_irq = 8'h80;
        idle(2);
        check("s6_irq_on", 32'(irq_out), 1);
        cfg_wr(32'h20, 0);
        step();
        check("s6_irq_off", 32'(irq_out), 0);
        cfg_rd(32'h23, 32'h80, "s6_pending_kept");
        cfg_rd(32'h22, 0, "s6_claim_none");
        cfg_wr(32'h20, 32'h80);
        step();
        check("s6_irq_restored", 32'(irq_out), 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) src_irq = N'($urandom);
            rst = ($urandom_range(0, 699) == 0);
            cfg_if.cfg_valid = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_wdata = $urandom;
                case ($urandom_range(0, 8))
                    0, 1: begin cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = 6'($urandom_range(0, N - 1)); end
                    2: begin cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = ADDR_ENABLE; end
                    3: begin
                        cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = ADDR_THRESH;
                        cfg_if.cfg_wdata = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 3));
                    end
                    4, 5: begin cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = ADDR_CLAIM; end
                    6: begin
                        cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = ADDR_CLAIM;
                        cfg_if.cfg_wdata = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 10));
                    end
                    7: begin cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 6'($urandom); end
                    default: begin cfg_if.cfg_we = 1'($urandom); cfg_if.cfg_addr = 6'($urandom); end
                endcase
            end
            step();
        end
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        idle(2);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
